tl_ul_buffer: RTL and testbench
===============================

Name: tl_ul_buffer

Overview:
- Registered TileLink-UL buffer for one 32-bit master/slave link.
- Sits directly downstream of the A/D pass-through adapter, between it and the crossbar port.
- Breaks combinational ready/valid paths on the A channel (master→slave) and the D channel (slave→master) with independent FIFOs.
- Counts outstanding requests and flags protocol errors.

Parameters:
- A_DEPTH, 2, A-channel FIFO entries (power of two, ≥2).
- D_DEPTH, 2, D-channel FIFO entries (power of two, ≥2).
- MAX_OUTSTANDING, 4, maximum accepted-but-unanswered A requests; further A acceptance is stalled at this limit.

Ports:
- clock  in  1  sole clock.
- reset  in  1  asynchronous, active-low reset.
- in_a_valid / in_a_ready  in/out  1/1  upstream A handshake.
- in_a_opcode  in  3  A opcode.
- in_a_param  in  3  A param.
- in_a_size  in  2  log2 transfer bytes.
- in_a_source  in  3  A source ID.
- in_a_address  in  32  A address.
- in_a_mask  in  4  byte lanes.
- in_a_data  in  32  A data.
- out_a_valid / out_a_ready  out/in  1/1  downstream A handshake.
- out_a_*  out  same widths  registered A fields.
- out_d_valid / out_d_ready  in/out  1/1  downstream D handshake (response arriving).
- out_d_opcode  in  3  D opcode.
- out_d_param  in  2  D param.
- out_d_size  in  2  D size.
- out_d_source  in  3  D source ID.
- out_d_denied  in  1  D denied flag.
- out_d_corrupt  in  1  D corrupt flag.
- out_d_data  in  32  D data.
- in_d_valid / in_d_ready  out/in  1/1  upstream D handshake.
- in_d_*  out  same widths  registered D fields.
- outstanding  out  3  current outstanding request count.
- err_unexpected_d  out  1  sticky; set by a D beat with zero outstanding.

Behaviour:
- Reset (asynchronous assert, synchronous-safe deassert):
  - both FIFOs empty; all pointers 0.
  - out_a_valid=0, in_d_valid=0; all registered payload fields 0.
  - outstanding=0, err_unexpected_d=0.
  - in_a_ready=0 while reset is asserted; in_a_ready=1 from the first clock after deassertion.
  - out_d_ready=1 from the first clock after deassertion.
- Reset mid-transfer: all buffered beats are discarded; no beat is replayed after reset.
- FIFOs (A and D identical):
  - Storage array plus rd/wr pointers of log2(DEPTH)+1 bits; the extra MSB distinguishes full from empty.
  - empty: pointers equal. full: index bits equal, MSBs differ.
  - Pointers wrap modulo 2·DEPTH.
  - Enqueue when valid_in && ready_out; dequeue when valid_out && ready_in.
  - ready_out = !full. valid_out = !empty.
  - No flow-through: a beat enqueued in cycle N is visible at the output no earlier than cycle N+1 (minimum latency 1).
  - Simultaneous enqueue and dequeue when full: the enqueue is not permitted (ready=0 that cycle).
  - Simultaneous enqueue and dequeue when non-empty and not full: both occur; occupancy unchanged.
- A acceptance gating:
  - in_a_ready = !a_full && (outstanding < MAX_OUTSTANDING).
  - in_a_ready must not depend combinationally on in_a_valid.
- Outstanding counter:
  - increments on an upstream A fire (in_a_valid && in_a_ready).
  - decrements on a downstream D fire (out_d_valid && out_d_ready).
  - both in the same cycle: count unchanged.
  - saturates at 0 and at MAX_OUTSTANDING.
- Unexpected D:
  - A D fire while outstanding==0 with no same-cycle A fire sets err_unexpected_d.
  - err_unexpected_d stays set until reset.
  - The beat itself is still buffered and forwarded.
- Payload integrity: fields pass unmodified; FIFO order is preserved; no reordering between sources.
- Stability: outputs hold stable while valid && !ready.

Decomposition:
- Package tl_ul_pkg:
  - width constants (TL_AW=32, TL_DW=32, TL_SZW=2, TL_SRCW=3).
  - packed structs tl_a_beat_t and tl_d_beat_t.
  - opcode enum: Get=4, PutFull=0, PutPartial=1, AccessAck=0, AccessAckData=1.
- One sub-module, tl_sync_fifo (parameters WIDTH, DEPTH), instantiated once for packed A beats and once for packed D beats.
- Counter and error logic live in the top module.

Test Plan:
- Single Get: A beat (addr 0x8000_0010, source 5) at cycle 0 with out_a_ready=1 → out_a_valid at cycle 1 with identical fields; outstanding=1. AccessAckData (data 0xDEAD_BEEF, source 5) → in_d_valid one cycle later with the same data; outstanding=0.
- Backpressure: out_a_ready=0, drive 3 A beats back-to-back → first 2 accepted, in_a_ready=0 on the 3rd. Release out_a_ready → beats emerge in order with stable payloads.
- Outstanding limit: keep out_d_valid=0, push 5 A beats with out_a_ready=1 → 4 accepted, outstanding=4, in_a_ready=0. One D fire → in_a_ready=1 next cycle.
- Simultaneous A fire and D fire at outstanding=2 → outstanding stays 2. Pointer wrap: stream 10 beats through a D FIFO with random in_d_ready → order preserved across wrap.
- Unexpected D: D beat at outstanding=0 → err_unexpected_d=1 the next cycle and sticky; the beat is still delivered.
- Reset mid-operation: assert reset with 2 beats queued in each FIFO → out_a_valid=0 and in_d_valid=0 immediately (asynchronous); outstanding=0 and err cleared; no stale beats after deassertion.

Source files
------------

// File: rtl/tl_ul_buffer_pkg.sv
// tl_ul_pkg: TileLink-UL widths, opcodes and packed beat layouts shared by the buffer
package tl_ul_pkg;
  localparam int TL_AW   = 32;
  localparam int TL_DW   = 32;
  localparam int TL_SZW  = 2;
  localparam int TL_SRCW = 3;
  localparam int TL_MW   = TL_DW / 8;

  typedef enum logic [2:0] {
    PutFull    = 3'd0,
    PutPartial = 3'd1,
    Get        = 3'd4
  } tl_a_op_e;

  typedef enum logic [2:0] {
    AccessAck     = 3'd0,
    AccessAckData = 3'd1
  } tl_d_op_e;

  typedef struct packed {
    logic [2:0]         opcode;
    logic [2:0]         param;
    logic [TL_SZW-1:0]  size;
    logic [TL_SRCW-1:0] source;
    logic [TL_AW-1:0]   address;
    logic [TL_MW-1:0]   mask;
    logic [TL_DW-1:0]   data;
  } tl_a_beat_t;

  typedef struct packed {
    logic [2:0]         opcode;
    logic [1:0]         param;
    logic [TL_SZW-1:0]  size;
    logic [TL_SRCW-1:0] source;
    logic               denied;
    logic               corrupt;
    logic [TL_DW-1:0]   data;
  } tl_d_beat_t;
endpackage

// File: rtl/tl_ul_buffer_fifo.sv
// tl_sync_fifo: registered FIFO with wrap-bit pointers; output always comes from storage, never flow-through
module tl_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [WIDTH-1:0] data_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH-1:0] data_o
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_q, rd_q;
  logic             full, enq, deq;
  assign full    = (wr_q ^ rd_q) == {1'b1, {AW{1'b0}}};
  assign ready_o = !full;
  assign valid_o = wr_q != rd_q;
  assign enq     = valid_i && ready_o;
  assign deq     = valid_o && ready_i;
  assign data_o  = mem_q[rd_q[AW-1:0]];
  // Pointer advance and storage write; reset discards every queued beat
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      mem_q <= '{default: '0};
      wr_q  <= '0;
      rd_q  <= '0;
    end else begin
      if (enq) mem_q[wr_q[AW-1:0]] <= data_i;
      if (enq) wr_q <= wr_q + (AW+1)'(1);
      if (deq) rd_q <= rd_q + (AW+1)'(1);
    end
  end
endmodule

// File: rtl/tl_ul_buffer.sv
// tl_ul_buffer: registered TL-UL A/D buffer with outstanding-request limit and unexpected-response flag
module tl_ul_buffer
  import tl_ul_pkg::*;
#(
  parameter int A_DEPTH         = 2,
  parameter int D_DEPTH         = 2,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               in_a_valid,
  output logic               in_a_ready,
  input  logic [2:0]         in_a_opcode,
  input  logic [2:0]         in_a_param,
  input  logic [TL_SZW-1:0]  in_a_size,
  input  logic [TL_SRCW-1:0] in_a_source,
  input  logic [TL_AW-1:0]   in_a_address,
  input  logic [TL_MW-1:0]   in_a_mask,
  input  logic [TL_DW-1:0]   in_a_data,
  output logic               out_a_valid,
  input  logic               out_a_ready,
  output logic [2:0]         out_a_opcode,
  output logic [2:0]         out_a_param,
  output logic [TL_SZW-1:0]  out_a_size,
  output logic [TL_SRCW-1:0] out_a_source,
  output logic [TL_AW-1:0]   out_a_address,
  output logic [TL_MW-1:0]   out_a_mask,
  output logic [TL_DW-1:0]   out_a_data,
  input  logic               out_d_valid,
  output logic               out_d_ready,
  input  logic [2:0]         out_d_opcode,
  input  logic [1:0]         out_d_param,
  input  logic [TL_SZW-1:0]  out_d_size,
  input  logic [TL_SRCW-1:0] out_d_source,
  input  logic               out_d_denied,
  input  logic               out_d_corrupt,
  input  logic [TL_DW-1:0]   out_d_data,
  output logic               in_d_valid,
  input  logic               in_d_ready,
  output logic [2:0]         in_d_opcode,
  output logic [1:0]         in_d_param,
  output logic [TL_SZW-1:0]  in_d_size,
  output logic [TL_SRCW-1:0] in_d_source,
  output logic               in_d_denied,
  output logic               in_d_corrupt,
  output logic [TL_DW-1:0]   in_d_data,
  output logic [2:0]         outstanding,
  output logic               err_unexpected_d
);
  localparam logic [2:0] MAX_CNT = 3'(MAX_OUTSTANDING);
  tl_a_beat_t a_in, a_out;
  tl_d_beat_t d_in, d_out;
  logic       live_q, a_en, a_rdy, d_rdy, a_fire, d_fire, err_q, err_d;
  logic [2:0] cnt_q, cnt_d;
  assign a_en        = live_q && cnt_q < MAX_CNT;
  assign in_a_ready  = a_rdy && a_en;
  assign out_d_ready = d_rdy && live_q;
  assign a_fire      = in_a_valid && in_a_ready;
  assign d_fire      = out_d_valid && out_d_ready;
  assign a_in = {in_a_opcode, in_a_param, in_a_size, in_a_source, in_a_address, in_a_mask, in_a_data};
  assign {out_a_opcode, out_a_param, out_a_size, out_a_source, out_a_address, out_a_mask, out_a_data} = a_out;
  assign d_in = {out_d_opcode, out_d_param, out_d_size, out_d_source, out_d_denied, out_d_corrupt, out_d_data};
  assign {in_d_opcode, in_d_param, in_d_size, in_d_source, in_d_denied, in_d_corrupt, in_d_data} = d_out;
  assign outstanding      = cnt_q;
  assign err_unexpected_d = err_q;

  tl_sync_fifo #(.WIDTH($bits(tl_a_beat_t)), .DEPTH(A_DEPTH)) u_a_fifo (
    .clock(clock), .reset(reset),
    .valid_i(in_a_valid && a_en), .ready_o(a_rdy), .data_i(a_in),
    .valid_o(out_a_valid), .ready_i(out_a_ready), .data_o(a_out)
  );

  tl_sync_fifo #(.WIDTH($bits(tl_d_beat_t)), .DEPTH(D_DEPTH)) u_d_fifo (
    .clock(clock), .reset(reset),
    .valid_i(out_d_valid && live_q), .ready_o(d_rdy), .data_i(d_in),
    .valid_o(in_d_valid), .ready_i(in_d_ready), .data_o(d_out)
  );

  // Saturating outstanding count; a response with nothing outstanding latches the error
  always_comb begin
    cnt_d = (a_fire && !d_fire && cnt_q != MAX_CNT) ? cnt_q + 3'd1 :
            (d_fire && !a_fire && cnt_q != 3'd0)    ? cnt_q - 3'd1 : cnt_q;
    err_d = err_q || (d_fire && !a_fire && cnt_q == 3'd0);
  end

  // live_q holds both upstream readies low until the first clock after reset release
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      live_q <= 1'b0;
      cnt_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      live_q <= 1'b1;
      cnt_q  <= cnt_d;
      err_q  <= err_d;
    end
  end
endmodule

// File: tb/tb_tl_ul_buffer.sv
// tb_tl_ul_buffer: directed scenarios plus randomized traffic against a queue-based link model
module tb_tl_ul_buffer;
  localparam int AD = 2, DD = 2, MAXO = 4;
  logic clock = 0, reset = 0;
  logic in_a_valid = 0, out_a_ready = 0, out_d_valid = 0, in_d_ready = 0;
  logic [2:0] in_a_opcode = 0, in_a_param = 0, in_a_source = 0, out_d_opcode = 0, out_d_source = 0;
  logic [1:0] in_a_size = 0, out_d_param = 0, out_d_size = 0;
  logic [31:0] in_a_address = 0, in_a_data = 0, out_d_data = 0;
  logic [3:0] in_a_mask = 0;
  logic out_d_denied = 0, out_d_corrupt = 0;
  logic in_a_ready, out_a_valid, out_d_ready, in_d_valid, in_d_denied, in_d_corrupt, err_unexpected_d;
  logic [2:0] out_a_opcode, out_a_param, out_a_source, in_d_opcode, in_d_source, outstanding;
  logic [1:0] out_a_size, in_d_param, in_d_size;
  logic [31:0] out_a_address, out_a_data, in_d_data;
  logic [3:0] out_a_mask;
  int tests = 0, fails = 0;

  tl_ul_buffer #(.A_DEPTH(AD), .D_DEPTH(DD), .MAX_OUTSTANDING(MAXO)) dut (
    .clock(clock), .reset(reset),
    .in_a_valid(in_a_valid), .in_a_ready(in_a_ready), .in_a_opcode(in_a_opcode), .in_a_param(in_a_param),
    .in_a_size(in_a_size), .in_a_source(in_a_source), .in_a_address(in_a_address), .in_a_mask(in_a_mask),
    .in_a_data(in_a_data),
    .out_a_valid(out_a_valid), .out_a_ready(out_a_ready), .out_a_opcode(out_a_opcode), .out_a_param(out_a_param),
    .out_a_size(out_a_size), .out_a_source(out_a_source), .out_a_address(out_a_address), .out_a_mask(out_a_mask),
    .out_a_data(out_a_data),
    .out_d_valid(out_d_valid), .out_d_ready(out_d_ready), .out_d_opcode(out_d_opcode), .out_d_param(out_d_param),
    .out_d_size(out_d_size), .out_d_source(out_d_source), .out_d_denied(out_d_denied),
    .out_d_corrupt(out_d_corrupt), .out_d_data(out_d_data),
    .in_d_valid(in_d_valid), .in_d_ready(in_d_ready), .in_d_opcode(in_d_opcode), .in_d_param(in_d_param),
    .in_d_size(in_d_size), .in_d_source(in_d_source), .in_d_denied(in_d_denied), .in_d_corrupt(in_d_corrupt),
    .in_d_data(in_d_data),
    .outstanding(outstanding), .err_unexpected_d(err_unexpected_d)
  );

  always #5 clock = ~clock;

  // Link model: each FIFO is a queue of whole beats, the counter plain saturating arithmetic
  logic [78:0] aq[$];
  logic [43:0] dq[$];
  logic [78:0] a_tmp;
  logic [43:0] d_tmp;
  int  m_cnt = 0;
  bit  m_err = 0, m_live = 0;
  bit  af, ao, df, dn;
  function automatic bit m_a_rdy();
    return m_live && aq.size() < AD && m_cnt < MAXO;
  endfunction
  function automatic bit m_d_rdy();
    return m_live && dq.size() < DD;
  endfunction
  wire [78:0] a_in_vec  = {in_a_opcode, in_a_param, in_a_size, in_a_source, in_a_address, in_a_mask, in_a_data};
  wire [78:0] a_out_vec = {out_a_opcode, out_a_param, out_a_size, out_a_source, out_a_address, out_a_mask, out_a_data};
  wire [43:0] d_in_vec  = {out_d_opcode, out_d_param, out_d_size, out_d_source, out_d_denied, out_d_corrupt, out_d_data};
  wire [43:0] d_out_vec = {in_d_opcode, in_d_param, in_d_size, in_d_source, in_d_denied, in_d_corrupt, in_d_data};

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      aq.delete(); dq.delete(); m_cnt = 0; m_err = 0; m_live = 0;
    end else begin
      af = in_a_valid && m_a_rdy();
      ao = aq.size() > 0 && out_a_ready;
      df = out_d_valid && m_d_rdy();
      dn = dq.size() > 0 && in_d_ready;
      if (ao) a_tmp = aq.pop_front();
      if (af) aq.push_back(a_in_vec);
      if (dn) d_tmp = dq.pop_front();
      if (df) dq.push_back(d_in_vec);
      if (df && !af && m_cnt == 0) m_err = 1;
      if (af && !df && m_cnt < MAXO) m_cnt++;
      else if (df && !af && m_cnt > 0) m_cnt--;
      m_live = 1;
    end
  end

  task automatic idle();
    in_a_valid = 0; out_d_valid = 0; out_a_ready = 1; in_d_ready = 1;
  endtask

  task automatic do_reset();
    idle();
    reset = 0;
    repeat (2) @(negedge clock);
    reset = 1;
    @(negedge clock);
  endtask

  task automatic set_a(input logic [31:0] addr, input logic [2:0] src, input logic [31:0] data);
    in_a_valid = 1; in_a_opcode = 3'd4; in_a_param = 0; in_a_size = 2'd2;
    in_a_source = src; in_a_address = addr; in_a_mask = 4'hf; in_a_data = data;
  endtask

  task automatic set_d(input logic [2:0] src, input logic [31:0] data);
    out_d_valid = 1; out_d_opcode = 3'd1; out_d_param = 0; out_d_size = 2'd2;
    out_d_source = src; out_d_denied = 0; out_d_corrupt = 0; out_d_data = data;
  endtask

  task automatic test_reset();
    idle();
    reset = 0;
    @(negedge clock);
    tests++;
    if ({in_a_ready, out_a_valid, in_d_valid, outstanding, err_unexpected_d} !== 7'b0) begin
      fails++; $display("FAIL reset_state got rdy=%b av=%b dv=%b cnt=%0d err=%b exp all 0",
        in_a_ready, out_a_valid, in_d_valid, outstanding, err_unexpected_d);
    end
    tests++;
    if ({out_a_address, out_a_data, in_d_data} !== 96'b0) begin
      fails++; $display("FAIL reset_payload got %h %h %h exp 0", out_a_address, out_a_data, in_d_data);
    end
    reset = 1;
    @(negedge clock);
    tests++;
    if ({in_a_ready, out_d_ready} !== 2'b11) begin
      fails++; $display("FAIL ready_after_reset got a=%b d=%b exp 1 1", in_a_ready, out_d_ready);
    end
  endtask

  task automatic test_single_get();
    do_reset();
    set_a(32'h8000_0010, 3'd5, 32'h0);
    @(negedge clock);
    in_a_valid = 0;
    tests++;
    if (out_a_valid !== 1 || out_a_address !== 32'h8000_0010 || out_a_source !== 3'd5 || out_a_opcode !== 3'd4) begin
      fails++; $display("FAIL get_a_out got v=%b addr=%h src=%0d op=%0d exp 1 80000010 5 4",
        out_a_valid, out_a_address, out_a_source, out_a_opcode);
    end
    tests++;
    if (outstanding !== 3'd1) begin
      fails++; $display("FAIL get_outstanding got %0d exp 1", outstanding);
    end
    set_d(3'd5, 32'hDEAD_BEEF);
    @(negedge clock);
    out_d_valid = 0;
    tests++;
    if (in_d_valid !== 1 || in_d_data !== 32'hDEAD_BEEF || in_d_source !== 3'd5 || in_d_opcode !== 3'd1) begin
      fails++; $display("FAIL get_d_out got v=%b data=%h src=%0d op=%0d exp 1 deadbeef 5 1",
        in_d_valid, in_d_data, in_d_source, in_d_opcode);
    end
    tests++;
    if (outstanding !== 3'd0 || err_unexpected_d !== 0) begin
      fails++; $display("FAIL get_done got cnt=%0d err=%b exp 0 0", outstanding, err_unexpected_d);
    end
  endtask

  task automatic test_backpressure();
    logic [2:0] acc = 0;
    do_reset();
    out_a_ready = 0;
    for (int i = 0; i < 3; i++) begin
      set_a(32'h100 + 32'(i * 4), 3'(i), 32'hA0 + 32'(i));
      #1 acc[i] = in_a_ready;
      @(negedge clock);
    end
    in_a_valid = 0;
    tests++;
    if (acc !== 3'b011) begin
      fails++; $display("FAIL bp_accept got %b exp 011", acc);
    end
    repeat (2) @(negedge clock);
    tests++;
    if (out_a_valid !== 1 || out_a_data !== 32'hA0) begin
      fails++; $display("FAIL bp_stable got v=%b data=%h exp 1 a0", out_a_valid, out_a_data);
    end
    out_a_ready = 1;
    @(negedge clock);
    tests++;
    if (out_a_valid !== 1 || out_a_data !== 32'hA1 || out_a_address !== 32'h104) begin
      fails++; $display("FAIL bp_order got v=%b data=%h addr=%h exp 1 a1 104", out_a_valid, out_a_data, out_a_address);
    end
    @(negedge clock);
    tests++;
    if (out_a_valid !== 0) begin
      fails++; $display("FAIL bp_drain got v=%b exp 0", out_a_valid);
    end
  endtask

  task automatic test_outstanding_limit();
    int acc = 0;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      set_a(32'h200 + 32'(i), 3'(i), 32'(i));
      #1 if (in_a_ready) acc++;
      @(negedge clock);
    end
    in_a_valid = 0;
    tests++;
    if (acc !== 4 || outstanding !== 3'd4 || in_a_ready !== 0) begin
      fails++; $display("FAIL limit got acc=%0d cnt=%0d rdy=%b exp 4 4 0", acc, outstanding, in_a_ready);
    end
    set_d(3'd0, 32'h1);
    @(negedge clock);
    out_d_valid = 0;
    tests++;
    if (outstanding !== 3'd3 || in_a_ready !== 1) begin
      fails++; $display("FAIL limit_release got cnt=%0d rdy=%b exp 3 1", outstanding, in_a_ready);
    end
  endtask

  task automatic test_simultaneous();
    do_reset();
    repeat (2) begin
      set_a(32'h300, 3'd1, 32'h0);
      @(negedge clock);
    end
    in_a_valid = 0;
    set_a(32'h304, 3'd2, 32'h0);
    set_d(3'd1, 32'h55);
    @(negedge clock);
    in_a_valid = 0; out_d_valid = 0;
    tests++;
    if (outstanding !== 3'd2 || in_d_valid !== 1 || in_d_data !== 32'h55) begin
      fails++; $display("FAIL simultaneous got cnt=%0d dv=%b data=%h exp 2 1 55", outstanding, in_d_valid, in_d_data);
    end
  endtask

  task automatic test_wrap();
    logic [31:0] exp[$];
    logic [31:0] e;
    int sent = 0, got = 0;
    do_reset();
    set_d(3'd3, 32'h0);
    for (int c = 0; c < 300 && got < 10; c++) begin
      out_d_valid = sent < 10;
      out_d_data = $urandom;
      in_d_ready = 1'($urandom_range(0, 1));
      #1;
      if (in_d_valid && in_d_ready) begin
        got++;
        e = exp.size() > 0 ? exp.pop_front() : 32'hx;
        tests++;
        if (in_d_data !== e) begin
          fails++; $display("FAIL wrap_order beat %0d got %h exp %h", got, in_d_data, e);
        end
      end
      if (out_d_valid && out_d_ready) begin exp.push_back(out_d_data); sent++; end
      @(negedge clock);
    end
    out_d_valid = 0;
    tests++;
    if (got != 10) begin
      fails++; $display("FAIL wrap_count got %0d exp 10", got);
    end
  endtask

  task automatic test_unexpected_d();
    do_reset();
    in_d_ready = 0;
    set_d(3'd6, 32'hCAFE_0001);
    @(negedge clock);
    out_d_valid = 0;
    tests++;
    if (err_unexpected_d !== 1 || in_d_valid !== 1 || in_d_data !== 32'hCAFE_0001) begin
      fails++; $display("FAIL unexpected_d got err=%b v=%b data=%h exp 1 1 cafe0001",
        err_unexpected_d, in_d_valid, in_d_data);
    end
    in_d_ready = 1;
    set_a(32'h400, 3'd0, 32'h0);
    repeat (3) @(negedge clock);
    in_a_valid = 0;
    tests++;
    if (err_unexpected_d !== 1) begin
      fails++; $display("FAIL unexpected_sticky got %b exp 1", err_unexpected_d);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    out_a_ready = 0; in_d_ready = 0;
    repeat (2) begin set_d(3'd1, 32'h77); @(negedge clock); end
    out_d_valid = 0;
    repeat (2) begin set_a(32'h500, 3'd1, 32'h88); @(negedge clock); end
    in_a_valid = 0;
    tests++;
    if (out_a_valid !== 1 || in_d_valid !== 1 || outstanding !== 3'd2 || err_unexpected_d !== 1) begin
      fails++; $display("FAIL mid_setup got av=%b dv=%b cnt=%0d err=%b exp 1 1 2 1",
        out_a_valid, in_d_valid, outstanding, err_unexpected_d);
    end
    #2 reset = 0;
    #1;
    tests++;
    if (out_a_valid !== 0 || in_d_valid !== 0 || outstanding !== 0 || err_unexpected_d !== 0) begin
      fails++; $display("FAIL mid_async got av=%b dv=%b cnt=%0d err=%b exp 0 0 0 0",
        out_a_valid, in_d_valid, outstanding, err_unexpected_d);
    end
    @(negedge clock);
    reset = 1;
    out_a_ready = 1; in_d_ready = 1;
    repeat (3) @(negedge clock);
    tests++;
    if (out_a_valid !== 0 || in_d_valid !== 0) begin
      fails++; $display("FAIL mid_stale got av=%b dv=%b exp 0 0", out_a_valid, in_d_valid);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 600; c++) begin
      tests++;
      if (in_a_ready !== m_a_rdy() || out_d_ready !== m_d_rdy()) begin
        fails++; $display("FAIL rnd_ready cyc %0d got a=%b d=%b exp a=%b d=%b", c, in_a_ready, out_d_ready, m_a_rdy(), m_d_rdy());
      end
      tests++;
      if (out_a_valid !== (aq.size() > 0) || (aq.size() > 0 && a_out_vec !== aq[0])) begin
        fails++; $display("FAIL rnd_a cyc %0d got v=%b %h exp v=%b", c, out_a_valid, a_out_vec, aq.size() > 0);
      end
      tests++;
      if (in_d_valid !== (dq.size() > 0) || (dq.size() > 0 && d_out_vec !== dq[0])) begin
        fails++; $display("FAIL rnd_d cyc %0d got v=%b %h exp v=%b", c, in_d_valid, d_out_vec, dq.size() > 0);
      end
      tests++;
      if (outstanding !== 3'(m_cnt) || err_unexpected_d !== m_err) begin
        fails++; $display("FAIL rnd_cnt cyc %0d got cnt=%0d err=%b exp %0d %b", c, outstanding, err_unexpected_d, m_cnt, m_err);
      end
      in_a_valid = 1'($urandom_range(0, 1)); out_a_ready = 1'($urandom_range(0, 1));
      out_d_valid = ($urandom_range(0, 3) == 0); in_d_ready = 1'($urandom_range(0, 1));
      in_a_opcode = 3'($urandom); in_a_param = 3'($urandom); in_a_size = 2'($urandom);
      in_a_source = 3'($urandom); in_a_address = $urandom; in_a_mask = 4'($urandom); in_a_data = $urandom;
      out_d_opcode = 3'($urandom); out_d_param = 2'($urandom); out_d_size = 2'($urandom);
      out_d_source = 3'($urandom); out_d_denied = 1'($urandom); out_d_corrupt = 1'($urandom); out_d_data = $urandom;
      @(negedge clock);
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_single_get();
    test_backpressure();
    test_outstanding_limit();
    test_simultaneous();
    test_wrap();
    test_unexpected_d();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
